// File: rtl/decoder_if.sv
// Decode-stage bus: raw instruction in, registered decoded fields and
// control strobes out. The decoder takes the slave side; whoever feeds
// instructions and consumes the decode takes the master side.
interface decoder_if #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 16
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;

  logic [2:0]         opcode;
  logic [4:0]         reg0;
  logic [4:0]         reg1;
  logic [4:0]         reg2;
  logic [ADDR_W-1:0]  addr;
  logic [INSTR_W-1:0] addr_sext;
  logic               out_valid;
  logic               is_mem;
  logic               is_branch;
  logic               is_alu;
  logic               mem_read;
  logic               mem_write;
  logic               reg_write;
  logic [1:0]         alu_op;

  modport slave (
    input  instr_valid, instruction,
    output opcode, reg0, reg1, reg2, addr, addr_sext, out_valid,
           is_mem, is_branch, is_alu, mem_read, mem_write, reg_write, alu_op
  );

  modport master (
    output instr_valid, instruction,
    input  opcode, reg0, reg1, reg2, addr, addr_sext, out_valid,
           is_mem, is_branch, is_alu, mem_read, mem_write, reg_write, alu_op
  );
endinterface

// File: rtl/decoder.sv
// Instruction decode stage. Slices the instruction word into opcode,
// register specifiers and address/offset (fields overlap on purpose),
// derives class flags and control strobes from the opcode, and registers
// everything so downstream logic sees a clean one-cycle-later decode.
module decoder #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  decoder_if.slave  bus
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_SW  = 3'd1;
  localparam logic [2:0] OP_BEQ = 3'd2;
  localparam logic [2:0] OP_BLT = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_OR  = 3'd7;

  logic [2:0] op_next;
  logic       is_mem_next;
  logic       is_branch_next;
  logic       is_alu_next;
  logic       mem_read_next;
  logic       mem_write_next;
  logic       reg_write_next;
  logic [1:0] alu_op_next;

  // Opcode to class flags and control strobes; every code is legal.
  always_comb begin
    op_next        = bus.instruction[INSTR_W-1 -: 3];
    is_mem_next    = 1'b0;
    is_branch_next = 1'b0;
    is_alu_next    = 1'b0;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    reg_write_next = 1'b0;
    alu_op_next    = 2'b00;
    case (op_next)
      OP_LW: begin
        is_mem_next    = 1'b1;
        mem_read_next  = 1'b1;
        reg_write_next = 1'b1;
      end
      OP_SW: begin
        is_mem_next    = 1'b1;
        mem_write_next = 1'b1;
      end
      OP_BEQ, OP_BLT: begin
        is_branch_next = 1'b1;
        alu_op_next    = 2'b01;
      end
      OP_ADD: begin
        is_alu_next    = 1'b1;
        reg_write_next = 1'b1;
        alu_op_next    = 2'b00;
      end
      OP_SUB: begin
        is_alu_next    = 1'b1;
        reg_write_next = 1'b1;
        alu_op_next    = 2'b01;
      end
      OP_AND: begin
        is_alu_next    = 1'b1;
        reg_write_next = 1'b1;
        alu_op_next    = 2'b10;
      end
      OP_OR: begin
        is_alu_next    = 1'b1;
        reg_write_next = 1'b1;
        alu_op_next    = 2'b11;
      end
      default: begin
        is_alu_next    = 1'b0;
      end
    endcase
  end

  // Capture fields and flags on a valid instruction, otherwise hold them; out_valid tracks instr_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.opcode    <= '0;
      bus.reg0      <= '0;
      bus.reg1      <= '0;
      bus.reg2      <= '0;
      bus.addr      <= '0;
      bus.addr_sext <= '0;
      bus.out_valid <= 1'b0;
      bus.is_mem    <= 1'b0;
      bus.is_branch <= 1'b0;
      bus.is_alu    <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.reg_write <= 1'b0;
      bus.alu_op    <= '0;
    end else begin
      bus.out_valid <= bus.instr_valid;
      if (bus.instr_valid) begin
        bus.opcode    <= op_next;
        bus.reg0      <= bus.instruction[28:24];
        bus.reg1      <= bus.instruction[23:19];
        bus.reg2      <= bus.instruction[18:14];
        bus.addr      <= bus.instruction[ADDR_W-1:0];
        bus.addr_sext <= {{(INSTR_W-ADDR_W){bus.instruction[ADDR_W-1]}},
                          bus.instruction[ADDR_W-1:0]};
        bus.is_mem    <= is_mem_next;
        bus.is_branch <= is_branch_next;
        bus.is_alu    <= is_alu_next;
        bus.mem_read  <= mem_read_next;
        bus.mem_write <= mem_write_next;
        bus.reg_write <= reg_write_next;
        bus.alu_op    <= alu_op_next;
      end
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for the decode stage.
module tb_decoder;

  logic clk;
  logic rst_n;

  decoder_if #(.INSTR_W(32), .ADDR_W(16)) bus ();

  decoder #(.INSTR_W(32), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks_total;
  int checks_passed;

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // flags = {out_valid, is_mem, is_branch, is_alu, mem_read, mem_write, reg_write, alu_op[1:0]}
  task automatic checkDecode(input string tag, input logic [2:0] op,
                             input logic [4:0] r0, input logic [4:0] r1,
                             input logic [4:0] r2, input logic [15:0] a,
                             input logic [31:0] sext, input logic [8:0] flags);
    checkOutput({tag, ".opcode"},    {29'd0, bus.opcode}, {29'd0, op});
    checkOutput({tag, ".reg0"},      {27'd0, bus.reg0},   {27'd0, r0});
    checkOutput({tag, ".reg1"},      {27'd0, bus.reg1},   {27'd0, r1});
    checkOutput({tag, ".reg2"},      {27'd0, bus.reg2},   {27'd0, r2});
    checkOutput({tag, ".addr"},      {16'd0, bus.addr},   {16'd0, a});
    checkOutput({tag, ".addr_sext"}, bus.addr_sext,       sext);
    checkOutput({tag, ".flags"},
                {23'd0, bus.out_valid, bus.is_mem, bus.is_branch, bus.is_alu,
                 bus.mem_read, bus.mem_write, bus.reg_write, bus.alu_op},
                {23'd0, flags});
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] word);
    @(negedge clk);
    bus.instr_valid = v;
    bus.instruction = word;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    checks_total  = 0;
    checks_passed = 0;

    // Reset held with a busy, all-ones instruction on the bus
    rst_n           = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instruction = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    checkDecode("reset", 3'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h0, 9'b0_000_000_00);

    // Release and decode LW rs=4 addr=7
    @(negedge clk);
    rst_n = 1'b1;
    w = {3'd0, 5'd4, 8'h00, 16'd7};
    applyStimulus(1'b1, w);
    checkDecode("lw", 3'd0, 5'd4, 5'd0, 5'd0, 16'd7, 32'd7, 9'b1_100_101_00);

    // SW, back to back
    w = {3'd1, 5'd4, 8'd0, 16'd7};
    applyStimulus(1'b1, w);
    checkDecode("sw", 3'd1, 5'd4, 5'd0, 5'd0, 16'd7, 32'd7, 9'b1_100_010_00);

    // Branches: reg2 slice picks up 3'b011 and addr[15:14]=00 -> 12
    w = {3'd2, 5'd2, 5'd6, 3'd3, 16'd6};
    applyStimulus(1'b1, w);
    checkDecode("beq", 3'd2, 5'd2, 5'd6, 5'd12, 16'd6, 32'd6, 9'b1_010_000_01);
    w = {3'd3, 5'd2, 5'd6, 3'd3, 16'd6};
    applyStimulus(1'b1, w);
    checkDecode("blt", 3'd3, 5'd2, 5'd6, 5'd12, 16'd6, 32'd6, 9'b1_010_000_01);

    // ALU ops each held four cycles; rd=7 puts 2'b11 in addr[15:14]
    for (int k = 0; k < 4; k++) begin
      logic [2:0] op;
      logic [1:0] aop;
      op  = 3'(4 + k);
      aop = 2'(k);
      w = {op, 5'd3, 5'd5, 5'd7, 14'd0};
      applyStimulus(1'b1, w);
      checkDecode($sformatf("alu%0d_first", k), op, 5'd3, 5'd5, 5'd7, 16'hC000,
                  32'hFFFF_C000, {7'b1_001_001, aop});
      repeat (3) @(posedge clk);
      #1;
      checkDecode($sformatf("alu%0d_held", k), op, 5'd3, 5'd5, 5'd7, 16'hC000,
                  32'hFFFF_C000, {7'b1_001_001, aop});
    end

    // Hold: valid ADD, then invalid with a different word
    w = {3'd4, 5'd3, 5'd5, 5'd7, 14'd0};
    applyStimulus(1'b1, w);
    checkDecode("hold_add", 3'd4, 5'd3, 5'd5, 5'd7, 16'hC000, 32'hFFFF_C000, 9'b1_001_001_00);
    applyStimulus(1'b0, 32'h2F0F_1234);
    checkDecode("hold_idle", 3'd4, 5'd3, 5'd5, 5'd7, 16'hC000, 32'hFFFF_C000, 9'b0_001_001_00);

    // Async reset pulse between edges
    w = {3'd0, 5'd9, 5'd1, 5'd2, 14'h0123};
    applyStimulus(1'b1, w);
    checkDecode("pre_rst", 3'd0, 5'd9, 5'd1, 5'd2, 16'h8123, 32'hFFFF_8123, 9'b1_100_101_00);
    #2;
    rst_n = 1'b0;
    #1;
    checkDecode("async_rst", 3'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h0, 9'b0_000_000_00);
    #1;
    rst_n = 1'b1;

    // First instruction after release
    w = {3'd6, 5'd31, 5'd16, 5'd1, 14'h3FFF};
    applyStimulus(1'b1, w);
    checkDecode("post_rst", 3'd6, 5'd31, 5'd16, 5'd1, 16'h7FFF, 32'h0000_7FFF, 9'b1_001_001_10);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
